// File: rtl/apb_timer.sv
// APB-style up-counter timer peripheral.
// Software writes a goal value, starts the counter, and polls status and the
// current count. The counter can be paused and resumed. Reading STATUS while
// the timer is COMPLETE returns COMPLETE and moves the timer back to IDLE.
//
// Register map (addr):
//   0 STATUS (R/W): bit0 START, bit1 STOP, bits3:2 state
//   1 GOAL   (R/W)
//   2 CURR   (read-only; a write is an error)
//   3 unmapped (any access is an error)
//
// Handshake: the bus has zero wait states. ready = sel & enable, and a transfer
// commits on the rising edge where sel & enable are both high. An errored
// transfer (slverr=1) changes no state and returns rdata=0.
module apb_timer #(
  parameter int timerbits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 enable,
  input  logic                 write,
  input  logic [1:0]           addr,
  input  logic [timerbits-1:0] wdata,
  output logic [timerbits-1:0] rdata,
  output logic                 ready,
  output logic                 slverr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 paused_q, paused_d;
  logic [timerbits-1:0] curr_q, curr_d;
  logic [timerbits-1:0] goal_q, goal_d;

  logic                 xfer;
  logic                 err;
  logic                 wr_en;
  logic                 rd_en;
  logic [timerbits-1:0] status_val;

  // Bus decode: access phase, error detection and committed read/write strobes.
  always_comb begin
    xfer   = sel & enable;
    err    = xfer & ((addr == 2'd3) | ((addr == 2'd2) & write));
    wr_en  = xfer & write & ~err;
    rd_en  = xfer & ~write & ~err;
    ready  = xfer;
    slverr = err;
  end

  // STATUS read image and read data mux; rdata is zero unless a clean read.
  always_comb begin
    status_val      = '0;
    status_val[0]   = (state_q == RUNNING) & ~paused_q;
    status_val[1]   = paused_q;
    status_val[3:2] = state_q;
    rdata           = '0;
    if (rd_en) begin
      case (addr)
        2'd0:    rdata = status_val;
        2'd1:    rdata = goal_q;
        2'd2:    rdata = curr_q;
        default: rdata = '0;
      endcase
    end
  end

  // Next-state: counting first, then bus effects which take priority over it.
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    curr_d   = curr_q;
    goal_d   = goal_q;

    // Counting: compare against goal, complete on equality, otherwise advance.
    // The counter is free to wrap if goal was lowered below curr.
    if ((state_q == RUNNING) && !paused_q) begin
      if (curr_q == goal_q) begin
        state_d = COMPLETE;
      end else begin
        curr_d = curr_q + 1'b1;
      end
    end

    if (wr_en && (addr == 2'd1)) begin
      goal_d = wdata;
    end

    // STOP wins over START. STOP pauses a running timer and freezes curr,
    // overriding any completion or increment on this edge.
    if (wr_en && (addr == 2'd0)) begin
      if (wdata[1]) begin
        if (state_q == RUNNING) begin
          paused_d = 1'b1;
          state_d  = RUNNING;
          curr_d   = curr_q;
        end
      end else if (wdata[0]) begin
        if (state_q != RUNNING) begin
          curr_d   = '0;
          paused_d = 1'b0;
          state_d  = RUNNING;
        end else if (paused_q) begin
          paused_d = 1'b0;
        end
      end
    end

    // Clear-on-read of the COMPLETE status.
    if (rd_en && (addr == 2'd0) && (state_q == COMPLETE)) begin
      state_d = IDLE;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      paused_q <= 1'b0;
      curr_q   <= '0;
      goal_q   <= '0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      curr_q   <= curr_d;
      goal_q   <= goal_d;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed scenarios followed by randomized bus traffic.
// Each driven cycle pushes its expected {ready, slverr, rdata} into a queue,
// computed from a behavioural model of the timer; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_apb_timer;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         sel;
  logic         enable;
  logic         write;
  logic [1:0]   addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         ready;
  logic         slverr;

  apb_timer #(.timerbits(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .enable (enable),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .slverr (slverr)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state 0 IDLE, 1 RUNNING, 2 COMPLETE.
  int m_state;
  int m_paused;
  int m_curr;
  int m_goal;

  // Scoreboard.
  logic [W+1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  // Drive one clock cycle of bus inputs, record the expected response and
  // advance the model to the state after the coming rising edge.
  task automatic cycle(input logic rst, input logic s, input logic e,
                       input logic w, input logic [1:0] a, input logic [W-1:0] d);
    logic         acc;
    logic         bad;
    logic [W-1:0] rd;
    int           ns, np, nc, ng;
    @(posedge clk);
    #1;
    reset = rst; sel = s; enable = e; write = w; addr = a; wdata = d;

    acc = s & e;
    bad = acc & ((a == 2'd3) | ((a == 2'd2) & w));
    rd  = '0;
    if (acc && !w && !bad) begin
      if (a == 2'd0) rd = W'(((m_state == 1 && m_paused == 0) ? 1 : 0) + m_paused * 2 + m_state * 4);
      else if (a == 2'd1) rd = W'(m_goal);
      else rd = W'(m_curr);
    end
    exp_q.push_back({acc, bad, rd});

    ns = m_state; np = m_paused; nc = m_curr; ng = m_goal;
    if (rst) begin
      ns = 0; np = 0; nc = 0; ng = 0;
    end else begin
      if (m_state == 1 && m_paused == 0) begin
        if (m_curr == m_goal) ns = 2;
        else nc = (m_curr + 1) % (1 << W);
      end
      if (acc && w && !bad && a == 2'd1) ng = int'(d);
      if (acc && w && !bad && a == 2'd0) begin
        if (d[1]) begin
          if (m_state == 1) begin np = 1; ns = 1; nc = m_curr; end
        end else if (d[0]) begin
          if (m_state != 1) begin nc = 0; np = 0; ns = 1; end
          else if (m_paused == 1) np = 0;
        end
      end
      if (acc && !w && !bad && a == 2'd0 && m_state == 2) ns = 0;
    end
    m_state = ns; m_paused = np; m_curr = nc; m_goal = ng;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  // APB transfer: setup phase then access phase.
  task automatic bus_wr(input logic [1:0] a, input logic [W-1:0] d);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, a, d);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic bus_rd(input logic [1:0] a);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, a, '0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, a, '0);
  endtask

  // Monitor: compare each driven cycle against its expected response.
  always @(negedge clk) begin
    logic [W+1:0] e;
    logic [W+1:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {ready, slverr, rdata};
      n_cmp++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL bus_resp t=%0t addr=%0d write=%0b: got ready=%0b slverr=%0b rdata=0x%02h, want ready=%0b slverr=%0b rdata=0x%02h",
                 $time, addr, write, act[W+1], act[W], act[W-1:0], e[W+1], e[W], e[W-1:0]);
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    m_state = 0; m_paused = 0; m_curr = 0; m_goal = 0;
    reset = 1'b1; sel = 1'b0; enable = 1'b0; write = 1'b0; addr = 2'd0; wdata = '0;

    // Reset and initial readback.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    idle(1);
    bus_rd(2'd0);
    bus_rd(2'd2);

    // Unmapped address and inactive bus cycles.
    bus_wr(2'd3, 8'h55);
    bus_rd(2'd3);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h01);
    bus_rd(2'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h01);
    bus_rd(2'd0);

    // Full count to 25 with polling and clear-on-read.
    bus_wr(2'd1, 8'd25);
    bus_wr(2'd0, 8'h01);
    bus_rd(2'd0);
    for (int i = 0; i < 15; i++) bus_rd(2'd2);
    bus_rd(2'd0);
    bus_rd(2'd0);
    bus_rd(2'd2);

    // Pause and resume.
    bus_wr(2'd0, 8'h01);
    idle(5);
    bus_wr(2'd0, 8'h03);
    bus_rd(2'd2);
    bus_rd(2'd2);
    bus_rd(2'd0);
    bus_wr(2'd0, 8'h01);
    idle(30);
    bus_rd(2'd2);
    bus_rd(2'd0);
    bus_rd(2'd0);

    // Goal zero completes one cycle after start; CURR write is an error.
    bus_wr(2'd1, 8'd0);
    bus_wr(2'd0, 8'h01);
    idle(1);
    bus_rd(2'd0);
    bus_rd(2'd2);
    bus_wr(2'd2, 8'hAA);
    bus_rd(2'd2);

    // Reset in the middle of a long count.
    bus_wr(2'd1, 8'd200);
    bus_wr(2'd0, 8'h01);
    idle(8);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
    bus_rd(2'd0);
    bus_rd(2'd2);
    bus_rd(2'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int           kind;
      logic [1:0]   a;
      logic [W-1:0] d;
      kind = int'($urandom_range(0, 99));
      a    = 2'($urandom_range(0, 3));
      if (kind < 2) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
      end else if (kind < 20) begin
        idle(int'($urandom_range(1, 6)));
      end else if (kind < 30) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), a, 8'($urandom));
      end else if (kind < 60) begin
        bus_rd(a);
      end else begin
        if (a == 2'd1) d = 8'($urandom_range(0, 40));
        else d = 8'($urandom);
        // While running and unpaused, only the pausing write is issued.
        if (a == 2'd0 && m_state == 1 && m_paused == 0) d[1] = 1'b1;
        bus_wr(a, d);
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
